// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: 8-bit CPU port, 32-bit block memory port.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_controller #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);
  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int NLINES   = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_UPDATE} state_t;

  state_t r_state, w_next;

  logic [NLINES-1:0]   r_valid, r_dirty;
  logic [TAG_BITS-1:0] r_tag  [NLINES];
  logic [31:0]         r_data [NLINES];

  logic [TAG_BITS-1:0]   r_cap_tag;
  logic [INDEX_BITS-1:0] r_idx;
  logic [31:0]           r_refill_data;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-1:0] w_off;
  logic [31:0]            w_line;
  logic w_req, w_hit, w_idle_hit, w_rd_hit, w_wr_hit, w_miss, w_mem_done;

  assign w_tag      = ADDRESS[7 -: TAG_BITS];
  assign w_idx      = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign w_off      = ADDRESS[OFFSET_BITS-1:0];
  assign w_line     = r_data[w_idx];
  assign w_req      = READ | WRITE;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle_hit = (r_state == S_IDLE) && w_hit;
  // READ with WRITE is a store
  assign w_rd_hit   = READ && !WRITE && w_idle_hit;
  assign w_wr_hit   = WRITE && w_idle_hit;
  assign w_miss     = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_mem_done = !MEM_BUSYWAIT;

  assign BUSYWAIT = w_req && !w_idle_hit;
  assign READDATA = w_rd_hit ? w_line[{w_off, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_miss) w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (w_mem_done) w_next = S_REFILL;
      S_REFILL:    if (w_mem_done) w_next = S_UPDATE;
      S_UPDATE:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    case (r_state)
      S_WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[r_idx], r_idx};
        MEM_WRITEDATA = r_data[r_idx];
      end
      S_REFILL: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_cap_tag, r_idx};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid       <= '0;
      r_dirty       <= '0;
      r_cap_tag     <= '0;
      r_idx         <= '0;
      r_refill_data <= '0;
    end else begin
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (w_miss) begin
        r_cap_tag <= w_tag;
        r_idx     <= w_idx;
      end
      if (r_state == S_REFILL && w_mem_done) r_refill_data <= MEM_READDATA;
      if (r_state == S_UPDATE) begin
        r_valid[r_idx] <= 1'b1;
        r_dirty[r_idx] <= 1'b0;
      end
    end
  end

  // Tag and data contents are qualified by valid, so they need no reset
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
    if (r_state == S_UPDATE) begin
      r_data[r_idx] <= r_refill_data;
      r_tag[r_idx]  <= r_cap_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic        r_after_refill;

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;

  // The hit that finishes a refilled access is not a true hit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_cnt      <= '0;
      r_miss_cnt     <= '0;
      r_after_refill <= 1'b0;
    end else begin
      if (r_state == S_UPDATE) r_after_refill <= 1'b1;
      else if (w_req && w_idle_hit) begin
        if (r_after_refill)            r_after_refill <= 1'b0;
        else if (r_hit_cnt != 16'hFFFF) r_hit_cnt     <= r_hit_cnt + 16'd1;
      end
      if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 3-cycle block memory responder.
module tb_dcache_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00, WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Block memory: busy for two cycles of a strobe, done on the third
  logic [31:0] mem_w [64];
  bit   [63:0] mem_wv;
  int          mcnt = 0;

  function automatic logic [31:0] mdef(input logic [5:0] a);
    logic [7:0] b;
    if (a == 6'h00) return 32'h44332211;
    if (a == 6'h08) return 32'h88776655;
    b = {a, 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < 2);
  assign MEM_READDATA = mem_wv[MEM_ADDRESS] ? mem_w[MEM_ADDRESS] : mdef(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) mcnt <= MEM_BUSYWAIT ? mcnt + 1 : 0;
    else                      mcnt <= 0;
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem_w[MEM_ADDRESS]  <= MEM_WRITEDATA;
      mem_wv[MEM_ADDRESS] <= 1'b1;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  t_rdata;
  int          t_stall;
  logic        t_saw_rd, t_saw_wr, t_both, t_done;
  logic [5:0]  t_rd_addr, t_wr_addr;
  logic [31:0] t_wr_data;

  // Called just after a falling edge; holds the request until BUSYWAIT drops
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    t_stall = 0; t_saw_rd = 0; t_saw_wr = 0; t_both = 0; t_done = 0;
    t_rd_addr = '0; t_wr_addr = '0; t_wr_data = '0; t_rdata = '0;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (MEM_READ)  begin t_saw_rd = 1; t_rd_addr = MEM_ADDRESS; end
      if (MEM_WRITE) begin t_saw_wr = 1; t_wr_addr = MEM_ADDRESS; t_wr_data = MEM_WRITEDATA; end
      if (MEM_READ && MEM_WRITE) t_both = 1;
      if (!BUSYWAIT) begin t_rdata = READDATA; t_done = 1; break; end
      t_stall++;
      @(negedge CLK);
    end
    check("access_done", t_done, 1'b1);
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
    @(negedge CLK);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_mem_read", MEM_READ, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITEDATA, 0);
    check("rst_busywait_idle", BUSYWAIT, 0);
    READ = 1;
    #1 check("rst_busywait_req", BUSYWAIT, 1);
    check("rst_readdata", READDATA, 0);
    READ = 0;
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);

    // Cold read miss: clean refill of block 0
    access(1, 0, 8'h00, 8'h00);
    check("m1_rdata", t_rdata, 8'h11);
    check("m1_stall", t_stall, 5);
    check("m1_mread", t_saw_rd, 1);
    check("m1_raddr", t_rd_addr, 6'h00);
    check("m1_mwrite", t_saw_wr, 0);

    // Read hit, zero stall
    access(1, 0, 8'h03, 8'h00);
    check("h1_rdata", t_rdata, 8'h44);
    check("h1_stall", t_stall, 0);
    check("h1_nostrobe", t_saw_rd | t_saw_wr, 0);

    // Write hit then conflicting read forces a write-back
    access(0, 1, 8'h01, 8'hAA);
    check("w1_stall", t_stall, 0);
    check("w1_rdata", t_rdata, 8'h00);
    access(1, 0, 8'h21, 8'h00);
    check("wb_stall", t_stall, 8);
    check("wb_mwrite", t_saw_wr, 1);
    check("wb_waddr", t_wr_addr, 6'h00);
    check("wb_wdata", t_wr_data, 32'h4433AA11);
    check("wb_raddr", t_rd_addr, 6'h08);
    check("wb_rdata", t_rdata, 8'h66);
    check("wb_exclusive", t_both, 0);
`ifdef DCACHE_STATS_EN
    check("st_hits", HIT_COUNT, 16'd2);
    check("st_miss", MISS_COUNT, 16'd2);
`endif

    // Clean valid victim: refill only, data comes back from the write-back
    access(1, 0, 8'h01, 8'h00);
    check("cm_stall", t_stall, 5);
    check("cm_mwrite", t_saw_wr, 0);
    check("cm_raddr", t_rd_addr, 6'h00);
    check("cm_rdata", t_rdata, 8'hAA);

    // Write miss: refill, then the store lands
    access(0, 1, 8'h68, 8'h77);
    check("wm_stall", t_stall, 5);
    check("wm_raddr", t_rd_addr, 6'h1A);
    access(1, 0, 8'h68, 8'h00);
    check("wm_hit_rdata", t_rdata, 8'h77);
    check("wm_hit_stall", t_stall, 0);
    access(1, 0, 8'h69, 8'h00);
    check("wm_neighbour", t_rdata, 8'h69);

    // Reset during refill
    READ = 1; ADDRESS = 8'h44;
    n = 0;
    #1;
    while (!MEM_READ && n < 20) begin @(negedge CLK); #1; n++; end
    check("rr_saw_mread", MEM_READ, 1);
    RESET = 0;
    #1;
    check("rr_mread_drop", MEM_READ, 0);
    check("rr_busywait", BUSYWAIT, 1);
    @(negedge CLK);
    READ = 0; RESET = 1;
    @(negedge CLK);
    access(1, 0, 8'h44, 8'h00);
    check("rr_remiss_stall", t_stall, 5);
    check("rr_remiss_raddr", t_rd_addr, 6'h11);
    check("rr_rdata", t_rdata, 8'h44);
    access(1, 0, 8'h00, 8'h00);
    check("rr_line0_cold", t_stall, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
